mealy_seq_detector: RTL

- Parametrised Mealy sequence detector over a stream of SYM_W-bit symbols; successor to the fixed 2-bit Mealy FSM.
- Pattern (up to DEPTH symbols) and its length are loaded at run time.
- Supports overlapping and non-overlapping detection, a qualifying enable, and a saturating hit counter.
- Sits on a symbol stream feeding control/status logic; the hit output is combinational from current input and registered history (Mealy).

---
 rtl/mealy_seq_pkg.sv | 15 +
 rtl/mealy_seq_detector_sym_history.sv | 31 +++
 rtl/mealy_seq_detector.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mealy_seq_pkg.sv
// Shared types and helpers for the run-time configurable Mealy sequence detector.
package mealy_seq_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    // Width of a field able to hold pattern lengths 0..depth.
    function automatic int unsigned len_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mealy_seq_detector_sym_history.sv
// Enabled shift register of the most recent symbols; entry 0 holds the newest.
module sym_history #(
    parameter int unsigned SYM_W = 2,
    parameter int unsigned N     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [SYM_W-1:0]   d,
    output logic [N*SYM_W-1:0] q
);

    logic [N-1:0][SYM_W-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (clr) begin
            mem <= '0;
        end else if (en) begin
            mem[0] <= d;
            for (int i = 1; i < int'(N); i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign q = mem;

endmodule

// File: rtl/mealy_seq_detector.sv
// Mealy detector for a run-time loaded pattern of up to DEPTH symbols, with
// overlap control, qualifying enable and a saturating hit counter.
module mealy_seq_detector
    import mealy_seq_pkg::*;
#(
    parameter int unsigned SYM_W = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [DEPTH*SYM_W-1:0]     cfg_pat,
    input  logic [$clog2(DEPTH+1)-1:0] cfg_len,
    input  logic                       cfg_ovl,
    input  logic                       en,
    input  logic [SYM_W-1:0]           a,
    output logic [1:0]                 y,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic                       armed
);

    localparam int unsigned LEN_W  = len_width(DEPTH);
    localparam int unsigned HIST_N = DEPTH - 1;

    state_t                   state, state_nxt;
    logic [LEN_W-1:0]         fill, fill_nxt;
    logic [LEN_W-1:0]         len_r;
    logic [DEPTH*SYM_W-1:0]   pat_r;
    logic                     ovl_r;
    logic [HIST_N*SYM_W-1:0]  hist;
    logic                     hit;
    logic                     hit_q;
    logic                     cfg_len_ok;
    logic                     tail_ok;
    logic                     last_ok;
    int                       len_i;
    int                       pidx;

    assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));

    sym_history #(
        .SYM_W (SYM_W),
        .N     (HIST_N)
    ) u_hist (
        .clk (clk),
        .rst (rst),
        .clr (cfg_we),
        .en  (en && !cfg_we),
        .d   (a),
        .q   (hist)
    );

    // Configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r <= '0;
            len_r <= '0;
            ovl_r <= 1'b0;
        end else if (cfg_we) begin
            pat_r <= cfg_pat;
            len_r <= cfg_len;
            ovl_r <= cfg_ovl;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= UNCFG;
            fill  <= '0;
        end else begin
            state <= state_nxt;
            fill  <= fill_nxt;
        end
    end

    // Next-state logic; a length-1 pattern needs no history so it arms at once
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        if (cfg_we) begin
            fill_nxt = '0;
            if (!cfg_len_ok) begin
                state_nxt = UNCFG;
            end else if (cfg_len == LEN_W'(1)) begin
                state_nxt = ARMED;
            end else begin
                state_nxt = FILL;
            end
        end else if (en) begin
            case (state)
                FILL: begin
                    fill_nxt = fill + LEN_W'(1);
                    if (fill + LEN_W'(1) == len_r - LEN_W'(1)) begin
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (hit && !ovl_r && len_r != LEN_W'(1)) begin
                        fill_nxt  = '0;
                        state_nxt = FILL;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // Output logic: compare history against pat[0..len-2], input against pat[len-1]
    always_comb begin
        tail_ok = 1'b1;
        last_ok = 1'b0;
        hit     = 1'b0;
        len_i   = int'(len_r);
        pidx    = 0;
        if (state == ARMED && len_i >= 1 && len_i <= int'(DEPTH)) begin
            for (int k = 0; k < int'(HIST_N); k++) begin
                if (k < len_i - 1) begin
                    pidx = len_i - 2 - k;
                    if (hist[k*SYM_W +: SYM_W] != pat_r[pidx*SYM_W +: SYM_W]) begin
                        tail_ok = 1'b0;
                    end
                end
            end
            last_ok = (a == pat_r[(len_i-1)*SYM_W +: SYM_W]);
            hit     = en && !cfg_we && tail_ok && last_ok;
        end
    end

    // Registered hit and saturating counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q   <= 1'b0;
            hit_cnt <= '0;
        end else begin
            hit_q <= cfg_we ? 1'b0 : hit;
            if (hit && hit_cnt != {CNT_W{1'b1}}) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
        end
    end

    assign y     = {hit_q, hit};
    assign armed = (state == ARMED);

endmodule
